// File: rtl/ct_f_spsram_2048x128_ctrl_if.sv
// Request/response bus for the 2048x128 SRAM controller.
// Handshake: a beat transfers on the rising edge where valid && ready are both high;
// valid never waits on ready, and ready never depends on valid.
interface ct_f_spsram_2048x128_ctrl_if;
   logic         req_vld;
   logic         req_rdy;
   logic         req_wr;
   logic [10:0]  req_addr;
   logic [127:0] req_wdata;
   logic         rsp_vld;
   logic         rsp_rdy;
   logic [127:0] rsp_rdata;

   modport master (
      output req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_rdata
   );

   modport slave (
      input  req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
      output req_rdy, rsp_vld, rsp_rdata
   );
endinterface

// File: rtl/ct_f_spsram_2048x128_ctrl.sv
// Request-side controller for the 2048x128 single-port SRAM wrapper: zero-fill after
// reset, then full-line reads/writes with in-order read data through a 4-entry FIFO.
module ct_f_spsram_2048x128_ctrl #(
   parameter logic INIT_EN = 1'b1
) (
   input  logic                          CLK,
   input  logic                          RST,
   ct_f_spsram_2048x128_ctrl_if.slave    bus,
   output logic                          init_done,
   output logic                          dbg_state,
   output logic [10:0]                   A,
   output logic                          CEN,
   output logic [127:0]                  D,
   output logic                          GWEN,
   output logic [127:0]                  WEN,
   input  logic [127:0]                  Q
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]   state;
   logic [10:0]  init_cnt;
   logic         inflight;
   logic [1:0]   wptr;
   logic [1:0]   rptr;
   logic [2:0]   occ;
   logic [127:0] fifo_mem [4];

   logic         run;
   logic         fire;
   logic         rd_fire;
   logic         push;
   logic         pop;
   logic [3:0]   credit_used;

   assign run         = (state == ST_RUN);
   assign dbg_state   = state[0];
   assign init_done   = run && !RST;

   // A read in the SRAM pipeline already owns a FIFO slot, so it counts against credit.
   assign credit_used = {1'b0, occ} + {3'b000, inflight};
   assign bus.req_rdy = run && !RST && (credit_used < 4'd4);
   assign fire        = bus.req_vld && bus.req_rdy;
   assign rd_fire     = fire && !bus.req_wr;

   assign push          = inflight;
   assign bus.rsp_vld   = (occ != 3'd0);
   assign pop           = bus.rsp_vld && bus.rsp_rdy;
   assign bus.rsp_rdata = fifo_mem[rptr];

   // SRAM pins are combinational so the array op lands on the same edge as the fire.
   always_comb begin
      CEN  = 1'b1;
      GWEN = 1'b1;
      A    = bus.req_addr;
      D    = bus.req_wdata;
      if (!RST) begin
         if (state == ST_INIT) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            A    = init_cnt;
            D    = '0;
         end else begin
            CEN  = !fire;
            GWEN = !(fire && bus.req_wr);
         end
      end
   end

   assign WEN = {128{GWEN}};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= INIT_EN ? ST_INIT : ST_RUN;
         init_cnt <= '0;
         inflight <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         occ      <= '0;
      end else begin
         if (state == ST_INIT) begin
            init_cnt <= init_cnt + 11'd1;
            if (init_cnt == 11'd2047) state <= ST_RUN;
         end
         inflight <= rd_fire;
         if (push) wptr <= wptr + 2'd1;
         if (pop)  rptr <= rptr + 2'd1;
         if (push && !pop)      occ <= occ + 3'd1;
         else if (!push && pop) occ <= occ - 3'd1;
      end
   end

   // Read data arrives one cycle after issue; capture it straight into the FIFO tail.
   always_ff @(posedge CLK) begin
      if (!RST && push) fifo_mem[wptr] <= Q;
   end

   always_ff @(posedge CLK) begin
      if (!RST) assert (!(push && occ == 3'd4));
   end

endmodule

// File: doc/ct_f_spsram_2048x128_ctrl.md
# ct_f_spsram_2048x128_ctrl

Request-side controller that sits directly upstream of the 2048x128 single-port FPGA SRAM wrapper and drives its active-low A/CEN/D/GWEN/WEN pins. It zero-fills the array after reset, then accepts full-line read/write requests over a valid/ready handshake. It returns read data in order through a 4-entry response FIFO with backpressure. Throughput is one request per cycle when the consumer keeps up.

## Interface
- INIT_EN, 1: 1 = zero-fill all 2048 lines after reset; 0 = enter RUN directly.
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready; a request fires when req_vld && req_rdy.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  11  line address.
- req_wdata  in  128  write data; full line only, no byte mask.
- rsp_vld  out  1  response FIFO head valid.
- rsp_rdy  in  1  consumer ready; pop when rsp_vld && rsp_rdy.
- rsp_rdata  out  128  response FIFO head data.
- init_done  out  1  high once in RUN.
- A  out  11  SRAM address.
- CEN  out  1  SRAM chip enable, active-low.
- D  out  128  SRAM write data.
- GWEN  out  1  SRAM global write enable, active-low.
- WEN  out  128  SRAM bit write enables, active-low. Always driven as {128{GWEN}}.
- Q  in  128  SRAM read data. Valid in the cycle after a read is issued.

## Operation
- FSM states: INIT and RUN.
  - RST forces INIT when INIT_EN=1, otherwise RUN.
  - INIT to RUN happens on the edge that issues the write to line 2047.
- INIT: an 11-bit counter starts at 0 and increments once per cycle. Each cycle drives CEN=0, GWEN=0, A=counter, D=0. req_rdy=0. The fill takes 2048 cycles.
- RUN, SRAM pins are combinational from the request:
  - CEN = !fire.
  - GWEN = !(fire && req_wr).
  - A = req_addr; D = req_wdata.
  - When idle, A and D are don't-care; tie them to the request inputs.
- Credit rule: req_rdy = RUN && (occ + inflight) < 4.
  - occ = FIFO occupancy, 0..4.
  - inflight = 1 if a read fired in the previous cycle.
  - req_rdy does not depend on req_vld, req_wr, or the same-cycle pop. Writes obey the same rule.
- Read pipeline:
  - A read fires at cycle T, which sets inflight for T+1.
  - At T+1, Q is written into the FIFO at the wptr edge.
  - Writes never enter the FIFO and never generate a response.
- FIFO:
  - 4 entries with 2-bit wrap-around read/write pointers and a 3-bit occupancy counter.
  - A push and a pop in the same cycle leave occ unchanged.
  - Overflow is impossible by the credit rule. Implementations must assert it with a check.
- Ordering: responses return in read-issue order. A write followed by a read to the same address returns the new data.
- Reset values:
  - req_rdy=0, rsp_vld=0, init_done=0 (INIT_EN=0: req_rdy=1 and init_done=1 the cycle after RST deasserts).
  - CEN=1 and GWEN=1 while RST is high.
  - occ, pointers, inflight and the counter are all 0. rsp_rdata is don't-care while rsp_vld=0.
- Reset mid-operation:
  - The in-flight read and all FIFO contents are discarded.
  - INIT restarts from line 0; with INIT_EN=0 the block re-enters RUN directly.
  - No response is emitted for requests accepted before RST.

## Timing
- Request fires at edge ending cycle T. The SRAM op happens at the same edge via the combinational pins.
- Read latency: rsp_vld is high in cycle T+2 at the earliest (fire T, Q sampled T+1, FIFO head T+2).
- Sustained throughput is 1 read/cycle with rsp_rdy=1; occ + inflight never exceeds 2 in that mode.
- When rsp_rdy=0, at most 4 reads are accepted, then req_rdy drops. req_rdy returns the cycle after the first pop.
- INIT_EN=1: RST high at cycle R, deasserted at R+1. Writes to lines 0..2047 happen in cycles R+1..R+2048. init_done and req_rdy go high at R+2049.

## Test plan
- Reset/init: INIT_EN=1, pulse RST one cycle, then:
  - require exactly 2048 CEN=0/GWEN=0 cycles with A = 0..2047 and D=0;
  - require init_done high at cycle 2049;
  - read addr 0x7FF and require rsp_rdata=0.
- Write/read: write 0xA5A5…A5 to 0x123, then read 0x123. Require rsp_vld exactly 2 cycles after the read fires, with matching data. Require no response for the write.
- Streaming: with rsp_rdy=1, issue 16 back-to-back reads of addr k (k = 0..15) holding pattern k. Require req_rdy constantly 1 and 16 in-order responses on consecutive cycles.
- Backpressure: with rsp_rdy=0, issue reads continuously.
  - Require exactly 4 accepted, then req_rdy=0 with no overflow.
  - Raise rsp_rdy for one cycle; require one pop and req_rdy=1 the next cycle.
- Wrap-around: run 10 read bursts of random lengths 1..4 with random rsp_rdy. Require scoreboard order and data to match across pointer wrap.
- Reset mid-stream: assert RST while 3 entries are queued and 1 read is in flight. Require rsp_vld=0 the next cycle, restart of INIT at line 0, and no stale responses afterwards.
